mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one Avalon-style memory port between the CPU instruction port (ip_*) and data port (dp_*).
- Turns the Harvard-style CPU interface into a single unified-memory bus.
- Sits between the CPU core and the unified RAM/bus.
- Serialises accesses, with data port ahead of instruction port, holds stall until every pending request is done, and latches read data per port.

Parameters:
- TIMEOUT_CYCLES, 256: consecutive waitrequest cycles on one access before bus_err sets; 0 disables the check.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ip_address  in  ADDR_W  instruction fetch address
- read_ip  in  1  instruction fetch request
- ip_readdata  out  32  latched fetch data
- dp_address  in  ADDR_W  data access address
- writedata  in  32  store data
- byteenable  in  4  store byte lanes
- read_dp  in  1  load request
- write_dp  in  1  store request
- dp_readdata  out  32  latched load data
- stall  out  1  CPU must hold all request inputs stable
- mem_address  out  ADDR_W  unified bus address
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_writedata  out  32  bus write data
- mem_byteenable  out  4  bus byte lanes
- mem_waitrequest  in  1  bus not ready; hold outputs
- mem_readdata  in  32  bus read data, valid in the cycle waitrequest is low
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: on rst high at a clock edge, state goes to IDLE. mem_read, mem_write, bus_err, ip_readdata and dp_readdata go to 0. Timeout counter clears. Reset mid-access abandons the access; strobes are low from the next cycle.
- dp_req = read_dp | write_dp. If read_dp and write_dp are both high, the write wins, no read is issued, and dp_readdata is unchanged.
- FSM states: IDLE, DATA, INSTR, DONE.
- IDLE:
  - stall = dp_req | read_ip (combinational).
  - If dp_req: register dp_address, writedata, byteenable and the read/write kind into the bus registers, then go to DATA.
  - Else if read_ip: register ip_address, then go to INSTR.
  - Else stay in IDLE.
- DATA:
  - Outputs: mem_read = the latched read kind, mem_write = the latched write kind, mem_byteenable = the latched byteenable on writes, 4'b1111 on reads.
  - stall = 1.
  - When mem_waitrequest is low: for a load, dp_readdata <= mem_readdata.
  - Next state: if read_ip, register ip_address and go to INSTR; else go to DONE.
- INSTR:
  - Outputs: mem_read = 1, mem_write = 0, mem_byteenable = 4'b1111.
  - stall = 1.
  - When mem_waitrequest is low: ip_readdata <= mem_readdata, then go to DONE.
- DONE: stall = 0 for exactly one cycle, which is when the CPU advances. Then go to IDLE unconditionally.
- Bus output rules:
  - All mem_* outputs are registered or decoded from state only.
  - They stay stable while waitrequest is high, even if CPU inputs change (which is a CPU protocol violation, but the access must still complete intact).
  - Strobes are 0 in IDLE and DONE.
- Latency with zero wait states:
  - Data-only or fetch-only request: 2 stall cycles (IDLE, then DATA or INSTR), then DONE.
  - Both requests together: 3 stall cycles (IDLE, DATA, INSTR), then DONE.
  - Each waitrequest cycle adds one stall cycle.
- Read data: ip_readdata and dp_readdata hold their last value until overwritten by a completing access of the same port. Stores never modify dp_readdata.
- Timeout counter:
  - Counts consecutive cycles in DATA or INSTR with waitrequest high; clears on completion.
  - When it reaches TIMEOUT_CYCLES, bus_err sets and stays set until rst. The FSM keeps waiting; the access is not aborted.
- Width: mem_address carries the full ADDR_W bits with no alignment changes; byte-lane handling belongs to the memory.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, DATA, INSTR, DONE) as a 2-bit typedef;
  - constant BE_ALL = 4'b1111.
- One natural sub-module, mem_arb_timeout: a parameterised saturating counter with a sticky flag. Inputs: clk, rst, count_en, clear. Output: expired.
- Everything else stays in the top module.

Test Plan:
- Fetch only, zero wait states: read_ip=1, ip_address=32'hbfc00000, memory returns 32'h3c011234 → stall high for 2 cycles then low for 1; mem_read pulses 1 cycle with mem_address=bfc00000; ip_readdata=3c011234.
- Simultaneous load and fetch: read_dp=1, dp_address=32'h00000ac0, read_ip=1, ip_address=bfc00004; memory returns 32'h00000011 for the load, then 32'h24020005 for the fetch → DATA precedes INSTR; stall lasts 3 cycles; dp_readdata=00000011, ip_readdata=24020005.
- Store with waitrequest held for 2 cycles: write_dp=1, byteenable=4'b1101, writedata=32'h11111111 → mem_write, mem_address and mem_writedata stay stable for 3 cycles; mem_byteenable=1101; dp_readdata unchanged; stall lasts 4 cycles.
- Read and write asserted together: read_dp=1, write_dp=1 → only mem_write is asserted; mem_read stays 0; dp_readdata is not updated.
- Timeout, with TIMEOUT_CYCLES=8: hold waitrequest high for 10 cycles during a fetch → bus_err rises after the 8th wait cycle; the fetch completes once waitrequest drops; bus_err stays high until rst.
- Reset mid-access: assert rst during INSTR with waitrequest high → next cycle state is IDLE, mem_read=0, ip_readdata=0, bus_err=0, stall follows the request inputs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing: one bus access at a time, data port before instruction port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating wait-cycle counter with a sticky expiry flag.
// A TIMEOUT_CYCLES of 0 keeps the flag permanently low.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic          expired_q, expired_d;

  // Next count: clear wins, otherwise count up to LIMIT and latch the flag on arrival.
  always_comb begin
    count_d   = count_q;
    expired_d = expired_q;
    if (TIMEOUT_CYCLES != 0) begin
      if (clear) begin
        count_d = '0;
      end else if (count_en && (count_q != LIMIT)) begin
        count_d = count_q + 1'b1;
        if (count_d == LIMIT) begin
          expired_d = 1'b1;
        end
      end
    end
  end

  // Counter and sticky flag registers; only reset drops the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the CPU instruction and data ports onto one Avalon-style memory bus.
// Data accesses go first; stall is held until every pending request finishes,
// then drops for exactly one cycle (DONE) so the CPU can advance.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ip_address,
  input  logic              read_ip,
  output logic [31:0]       ip_readdata,
  input  logic [ADDR_W-1:0] dp_address,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              read_dp,
  input  logic              write_dp,
  output logic [31:0]       dp_readdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              wr_q, rd_q;
  logic [31:0]       ip_rdata_q, dp_rdata_q;
  logic              dp_req, load_dp, load_ip, in_access;

  assign dp_req    = read_dp | write_dp;
  assign in_access = (state_q == DATA) || (state_q == INSTR);

  // Next-state, bus-register load enables and stall decode.
  always_comb begin
    state_d = state_q;
    load_dp = 1'b0;
    load_ip = 1'b0;
    stall   = 1'b1;
    case (state_q)
      IDLE: begin
        stall = dp_req | read_ip;
        if (dp_req) begin
          load_dp = 1'b1;
          state_d = DATA;
        end else if (read_ip) begin
          load_ip = 1'b1;
          state_d = INSTR;
        end
      end
      DATA: begin
        if (!mem_waitrequest) begin
          if (read_ip) begin
            load_ip = 1'b1;
            state_d = INSTR;
          end else begin
            state_d = DONE;
          end
        end
      end
      INSTR: begin
        if (!mem_waitrequest) begin
          state_d = DONE;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and access kind; a simultaneous read+write becomes a write only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_dp) begin
        wr_q <= write_dp;
        rd_q <= read_dp & ~write_dp;
      end
    end
  end

  // Bus address/data registers; captured once per access so they hold through waitrequest.
  always_ff @(posedge clk) begin
    if (load_dp) begin
      addr_q  <= dp_address;
      wdata_q <= writedata;
      be_q    <= byteenable;
    end else if (load_ip) begin
      addr_q  <= ip_address;
    end
  end

  // Per-port read data, updated only by a completing read of that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ip_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      if ((state_q == DATA) && !mem_waitrequest && rd_q) begin
        dp_rdata_q <= mem_readdata;
      end
      if ((state_q == INSTR) && !mem_waitrequest) begin
        ip_rdata_q <= mem_readdata;
      end
    end
  end

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .count_en(in_access & mem_waitrequest),
    .clear   (~(in_access & mem_waitrequest)),
    .expired (bus_err)
  );

  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_read       = ((state_q == DATA) && rd_q) || (state_q == INSTR);
  assign mem_write      = (state_q == DATA) && wr_q;
  assign mem_byteenable = ((state_q == DATA) && wr_q) ? be_q : BE_ALL;
  assign ip_readdata    = ip_rdata_q;
  assign dp_readdata    = dp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written timeout and reset-mid-access sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip_address, dp_address, writedata, mem_readdata;
  logic        read_ip, read_dp, write_dp, mem_waitrequest;
  logic [3:0]  byteenable;
  logic [31:0] ip_readdata, dp_readdata, mem_address, mem_writedata;
  logic        stall, mem_read, mem_write, bus_err;
  logic [3:0]  mem_byteenable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ip_address(ip_address), .read_ip(read_ip), .ip_readdata(ip_readdata),
    .dp_address(dp_address), .writedata(writedata), .byteenable(byteenable),
    .read_dp(read_dp), .write_dp(write_dp), .dp_readdata(dp_readdata),
    .stall(stall), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        rip;  logic [31:0] ipa;
    logic        rdp;  logic        wdp;
    logic [31:0] dpa;  logic [31:0] wd;  logic [3:0] be;
    logic        wt;   logic [31:0] rdat;
    logic        e_stall; logic e_mrd; logic e_mwr;
    logic [31:0] e_addr;  logic [31:0] e_wd; logic [3:0] e_be;
    logic [31:0] e_ip;    logic [31:0] e_dp;
  } vec_t;

  vec_t vec [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    read_ip = v.rip;  ip_address = v.ipa;
    read_dp = v.rdp;  write_dp = v.wdp;
    dp_address = v.dpa; writedata = v.wd; byteenable = v.be;
    mem_waitrequest = v.wt; mem_readdata = v.rdat;
  endtask

  task automatic idle_inputs();
    read_ip = 0; ip_address = 0; read_dp = 0; write_dp = 0;
    dp_address = 0; writedata = 0; byteenable = 0;
    mem_waitrequest = 0; mem_readdata = 0;
  endtask

  initial begin
    // rip ipa rdp wdp dpa wd be wt rdat | stall mrd mwr addr wd be ip dp
    // Fetch only, zero wait states
    vec[0]  = '{1, 32'hbfc00000, 0, 0, 0, 0, 4'h0, 0, 0,            1, 0, 0, 0, 0, 4'h0, 0, 0};
    vec[1]  = '{1, 32'hbfc00000, 0, 0, 0, 0, 4'h0, 0, 32'h3c011234, 1, 1, 0, 32'hbfc00000, 0, 4'hf, 0, 0};
    vec[2]  = '{1, 32'hbfc00000, 0, 0, 0, 0, 4'h0, 0, 0,            0, 0, 0, 0, 0, 4'h0, 32'h3c011234, 0};
    vec[3]  = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                       0, 0, 0, 0, 0, 4'h0, 32'h3c011234, 0};
    // Load and fetch together: DATA then INSTR
    vec[4]  = '{1, 32'hbfc00004, 1, 0, 32'h00000ac0, 0, 4'h0, 0, 0,            1, 0, 0, 0, 0, 4'h0, 32'h3c011234, 0};
    vec[5]  = '{1, 32'hbfc00004, 1, 0, 32'h00000ac0, 0, 4'h0, 0, 32'h00000011, 1, 1, 0, 32'h00000ac0, 0, 4'hf, 32'h3c011234, 0};
    vec[6]  = '{1, 32'hbfc00004, 1, 0, 32'h00000ac0, 0, 4'h0, 0, 32'h24020005, 1, 1, 0, 32'hbfc00004, 0, 4'hf, 32'h3c011234, 32'h11};
    vec[7]  = '{1, 32'hbfc00004, 1, 0, 32'h00000ac0, 0, 4'h0, 0, 0,            0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    vec[8]  = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                                   0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    // Store with two wait cycles; CPU inputs wobble mid-access
    vec[9]  = '{0, 0, 0, 1, 32'h100, 32'h11111111, 4'hd, 0, 0,            1, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    vec[10] = '{0, 0, 0, 1, 32'h100, 32'h11111111, 4'hd, 1, 0,            1, 0, 1, 32'h100, 32'h11111111, 4'hd, 32'h24020005, 32'h11};
    vec[11] = '{0, 0, 0, 1, 32'h200, 32'h22222222, 4'h3, 1, 0,            1, 0, 1, 32'h100, 32'h11111111, 4'hd, 32'h24020005, 32'h11};
    vec[12] = '{0, 0, 0, 1, 32'h100, 32'h11111111, 4'hd, 0, 32'hdeadbeef, 1, 0, 1, 32'h100, 32'h11111111, 4'hd, 32'h24020005, 32'h11};
    vec[13] = '{0, 0, 0, 1, 32'h100, 32'h11111111, 4'hd, 0, 0,            0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    vec[14] = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                             0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    // Read and write together: write wins
    vec[15] = '{0, 0, 1, 1, 32'h300, 32'h33333333, 4'hf, 0, 0,            1, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    vec[16] = '{0, 0, 1, 1, 32'h300, 32'h33333333, 4'hf, 0, 32'hcafef00d, 1, 0, 1, 32'h300, 32'h33333333, 4'hf, 32'h24020005, 32'h11};
    vec[17] = '{0, 0, 1, 1, 32'h300, 32'h33333333, 4'hf, 0, 0,            0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};
    vec[18] = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                             0, 0, 0, 0, 0, 4'h0, 32'h24020005, 32'h11};

    // Reset and reset-state checks
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_mem_read", {31'd0, mem_read}, 0);
    check("rst_mem_write", {31'd0, mem_write}, 0);
    check("rst_bus_err", {31'd0, bus_err}, 0);
    check("rst_ip_readdata", ip_readdata, 0);
    check("rst_dp_readdata", dp_readdata, 0);
    @(posedge clk); #1;
    rst = 0;

    // Table-driven cycles
    for (int i = 0; i < 19; i++) begin
      drive(vec[i]);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vec[i].e_stall});
      check($sformatf("v%0d_mem_read", i), {31'd0, mem_read}, {31'd0, vec[i].e_mrd});
      check($sformatf("v%0d_mem_write", i), {31'd0, mem_write}, {31'd0, vec[i].e_mwr});
      check($sformatf("v%0d_bus_err", i), {31'd0, bus_err}, 0);
      check($sformatf("v%0d_ip_readdata", i), ip_readdata, vec[i].e_ip);
      check($sformatf("v%0d_dp_readdata", i), dp_readdata, vec[i].e_dp);
      if (vec[i].e_mrd || vec[i].e_mwr) begin
        check($sformatf("v%0d_mem_address", i), mem_address, vec[i].e_addr);
        check($sformatf("v%0d_mem_byteenable", i), {28'd0, mem_byteenable}, {28'd0, vec[i].e_be});
      end
      if (vec[i].e_mwr)
        check($sformatf("v%0d_mem_writedata", i), mem_writedata, vec[i].e_wd);
      @(posedge clk); #1;
    end

    // Timeout: fetch held off by 10 wait cycles, limit 8
    idle_inputs();
    read_ip = 1; ip_address = 32'hbfc00010; mem_waitrequest = 1;
    @(negedge clk);
    check("to_idle_stall", {31'd0, stall}, 1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("to_w%0d_mem_read", i), {31'd0, mem_read}, 1);
      check($sformatf("to_w%0d_addr", i), mem_address, 32'hbfc00010);
      check($sformatf("to_w%0d_bus_err", i), {31'd0, bus_err}, (i >= 9) ? 1 : 0);
    end
    @(posedge clk); #1;
    mem_waitrequest = 0; mem_readdata = 32'h12345678;
    @(negedge clk);
    check("to_final_mem_read", {31'd0, mem_read}, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_done_stall", {31'd0, stall}, 0);
    check("to_ip_readdata", ip_readdata, 32'h12345678);
    check("to_bus_err_sticky", {31'd0, bus_err}, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("to_idle_bus_err", {31'd0, bus_err}, 1);

    // Reset during a stalled fetch
    @(posedge clk); #1;
    read_ip = 1; ip_address = 32'hbfc00020; mem_waitrequest = 1;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rm_pre_mem_read", {31'd0, mem_read}, 1);
    @(posedge clk); #1;
    rst = 0; read_ip = 0;
    @(negedge clk);
    check("rm_mem_read", {31'd0, mem_read}, 0);
    check("rm_ip_readdata", ip_readdata, 0);
    check("rm_bus_err", {31'd0, bus_err}, 0);
    check("rm_stall_idle", {31'd0, stall}, 0);
    read_ip = 1;
    #1;
    check("rm_stall_follows", {31'd0, stall}, 1);
    read_ip = 0;
    #1;
    check("rm_stall_drops", {31'd0, stall}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
